// File: rtl/qpolicy_rollout.sv
// Greedy rollout engine over a trained 5x5 Q-table: reads four Q-values per cell,
// takes the signed argmax, moves (clamped) and streams each move over valid/ready.
module qpolicy_rollout #(
  parameter int unsigned QW        = 16,
  parameter int unsigned MAX_STEPS = 24
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  output logic                 q_rd_en,
  output logic [2:0]           q_rd_x,
  output logic [2:0]           q_rd_y,
  output logic [1:0]           q_rd_a,
  input  logic signed [QW-1:0] q_rd_data,
  output logic                 mv_valid,
  input  logic                 mv_ready,
  output logic [1:0]           mv_action,
  output logic [2:0]           mv_x,
  output logic [2:0]           mv_y,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           result,
  output logic [4:0]           steps
);

  localparam int unsigned CW = 3;
  localparam int unsigned AW = 2;
  localparam int unsigned RW = 2;
  localparam int unsigned SW = 5;

  localparam logic [RW-1:0] RES_GOAL    = 2'd1;
  localparam logic [RW-1:0] RES_HOLE    = 2'd2;
  localparam logic [RW-1:0] RES_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_LAST = 3'd2,
    S_EMIT = 3'd3,
    S_FIN  = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]         pos_x_q, pos_x_d;
  logic [CW-1:0]         pos_y_q, pos_y_d;
  logic signed [QW-1:0]  best_val_q, best_val_d;
  logic [AW-1:0]         best_act_q, best_act_d;
  logic                  q_rd_en_q, q_rd_en_d;
  logic [AW-1:0]         q_rd_a_q, q_rd_a_d;
  logic                  mv_valid_q, mv_valid_d;
  logic [AW-1:0]         mv_action_q, mv_action_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [RW-1:0]         result_q, result_d;
  logic [SW-1:0]         steps_q, steps_d;

  logic [AW-1:0]         act_c;
  logic                  at_goal_c;
  logic                  at_hole_c;

  // Final argmax step: action 3 wins only on a strictly greater value.
  assign act_c     = (q_rd_data > best_val_q) ? AW'(3) : best_act_q;
  assign at_goal_c = (pos_x_q == CW'(4)) && (pos_y_q == CW'(4));
  assign at_hole_c = ((pos_x_q == CW'(1)) && (pos_y_q == CW'(0))) ||
                     ((pos_x_q == CW'(3)) && (pos_y_q == CW'(1))) ||
                     ((pos_x_q == CW'(4)) && (pos_y_q == CW'(2))) ||
                     ((pos_x_q == CW'(1)) && (pos_y_q == CW'(3)));

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    best_val_d  = best_val_q;
    best_act_d  = best_act_q;
    q_rd_en_d   = q_rd_en_q;
    q_rd_a_d    = q_rd_a_q;
    mv_valid_d  = mv_valid_q;
    mv_action_d = mv_action_q;
    busy_d      = busy_q;
    done_d      = done_q;
    result_d    = result_q;
    steps_d     = steps_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pos_x_d   = '0;
          pos_y_d   = '0;
          steps_d   = '0;
          result_d  = '0;
          done_d    = 1'b0;
          busy_d    = 1'b1;
          q_rd_en_d = 1'b1;
          q_rd_a_d  = '0;
          rd_cnt_d  = '0;
          state_d   = S_READ;
        end
      end

      S_READ: begin
        rd_cnt_d = rd_cnt_q + AW'(1);
        // Data trails the address by one cycle, so it belongs to action rd_cnt-1.
        if (rd_cnt_q == AW'(1)) begin
          best_val_d = q_rd_data;
          best_act_d = '0;
        end else if ((rd_cnt_q != AW'(0)) && (q_rd_data > best_val_q)) begin
          best_val_d = q_rd_data;
          best_act_d = rd_cnt_q - AW'(1);
        end
        if (rd_cnt_q == AW'(3)) begin
          q_rd_en_d = 1'b0;
          state_d   = S_LAST;
        end else begin
          q_rd_a_d  = rd_cnt_q + AW'(1);
        end
      end

      S_LAST: begin
        case (act_c)
          2'd0:    if (pos_y_q != CW'(4)) pos_y_d = pos_y_q + CW'(1);
          2'd1:    if (pos_y_q != CW'(0)) pos_y_d = pos_y_q - CW'(1);
          2'd2:    if (pos_x_q != CW'(0)) pos_x_d = pos_x_q - CW'(1);
          default: if (pos_x_q != CW'(4)) pos_x_d = pos_x_q + CW'(1);
        endcase
        mv_action_d = act_c;
        mv_valid_d  = 1'b1;
        steps_d     = steps_q + SW'(1);
        state_d     = S_EMIT;
      end

      S_EMIT: begin
        if (mv_ready) begin
          mv_valid_d = 1'b0;
          if (at_goal_c) begin
            result_d = RES_GOAL;
            state_d  = S_FIN;
          end else if (at_hole_c) begin
            result_d = RES_HOLE;
            state_d  = S_FIN;
          end else if (steps_q == SW'(MAX_STEPS)) begin
            result_d = RES_TIMEOUT;
            state_d  = S_FIN;
          end else begin
            q_rd_en_d = 1'b1;
            q_rd_a_d  = '0;
            rd_cnt_d  = '0;
            state_d   = S_READ;
          end
        end
      end

      S_FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rd_cnt_q    <= '0;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      best_val_q  <= '0;
      best_act_q  <= '0;
      q_rd_en_q   <= 1'b0;
      q_rd_a_q    <= '0;
      mv_valid_q  <= 1'b0;
      mv_action_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      steps_q     <= '0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      best_val_q  <= best_val_d;
      best_act_q  <= best_act_d;
      q_rd_en_q   <= q_rd_en_d;
      q_rd_a_q    <= q_rd_a_d;
      mv_valid_q  <= mv_valid_d;
      mv_action_q <= mv_action_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      steps_q     <= steps_d;
    end
  end

  // Read address and move payload both come straight from the position register.
  assign q_rd_en   = q_rd_en_q;
  assign q_rd_x    = pos_x_q;
  assign q_rd_y    = pos_y_q;
  assign q_rd_a    = q_rd_a_q;
  assign mv_valid  = mv_valid_q;
  assign mv_action = mv_action_q;
  assign mv_x      = pos_x_q;
  assign mv_y      = pos_y_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign steps     = steps_q;

endmodule

// File: tb/tb_qpolicy_rollout.sv
// Bench for qpolicy_rollout: Q-table memory model, move monitor and a
// grid-walk reference model driven by directed and randomized rollouts.
module tb_qpolicy_rollout;

  localparam int QW        = 16;
  localparam int MAX_STEPS = 24;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 start;
  logic                 q_rd_en;
  logic [2:0]           q_rd_x, q_rd_y;
  logic [1:0]           q_rd_a;
  logic signed [QW-1:0] q_rd_data;
  logic                 mv_valid;
  logic                 mv_ready;
  logic [1:0]           mv_action;
  logic [2:0]           mv_x, mv_y;
  logic                 busy, done;
  logic [1:0]           result;
  logic [4:0]           steps;

  qpolicy_rollout #(.QW(QW), .MAX_STEPS(MAX_STEPS)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .q_rd_en(q_rd_en), .q_rd_x(q_rd_x), .q_rd_y(q_rd_y), .q_rd_a(q_rd_a),
    .q_rd_data(q_rd_data),
    .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_action(mv_action),
    .mv_x(mv_x), .mv_y(mv_y),
    .busy(busy), .done(done), .result(result), .steps(steps)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic signed [QW-1:0] q_mem [0:4][0:4][0:3];
  logic [7:0]           obs_q[$];
  logic [7:0]           exp_q[$];
  int                   exp_result;
  int                   exp_steps;
  bit                   bp_en       = 1'b0;
  logic                 force_ready = 1'b1;

  // One-cycle-latency Q-table read port.
  always @(posedge clk) begin
    if (q_rd_en && q_rd_x < 3'd5 && q_rd_y < 3'd5) q_rd_data <= q_mem[q_rd_x][q_rd_y][q_rd_a];
  end

  // Ready driver: fixed level or random backpressure.
  always @(posedge clk) begin
    #2;
    mv_ready = bp_en ? ($urandom_range(0, 3) != 0) : force_ready;
  end

  // Move monitor: a handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (reset_n && mv_valid && mv_ready) obs_q.push_back({mv_action, mv_x, mv_y});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic fill_q(input int mode);
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        for (int a = 0; a < 4; a++)
          case (mode)
            0:       q_mem[x][y][a] = '0;
            1:       q_mem[x][y][a] = 16'($urandom_range(0, 6)) - 16'd3;
            default: q_mem[x][y][a] = 16'($urandom);
          endcase
  endtask

  // Reference: greedy walk on the grid with signed argmax, lowest index on ties.
  task automatic compute_expected();
    int x, y, n, best_a, res;
    x = 0; y = 0; n = 0; res = 0;
    exp_q.delete();
    while (res == 0) begin
      best_a = 0;
      for (int a = 1; a < 4; a++)
        if (int'(q_mem[x][y][a]) > int'(q_mem[x][y][best_a])) best_a = a;
      case (best_a)
        0:       y = (y < 4) ? y + 1 : y;
        1:       y = (y > 0) ? y - 1 : y;
        2:       x = (x > 0) ? x - 1 : x;
        default: x = (x < 4) ? x + 1 : x;
      endcase
      n++;
      exp_q.push_back({2'(best_a), 3'(x), 3'(y)});
      if (x == 4 && y == 4) res = 1;
      else if ((x == 1 && y == 0) || (x == 3 && y == 1) || (x == 4 && y == 2) || (x == 1 && y == 3)) res = 2;
      else if (n == MAX_STEPS) res = 3;
    end
    exp_result = res;
    exp_steps  = n;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"},  32'(q_rd_en), 0);
    check({tag, "_rd_xya"}, 32'({q_rd_x, q_rd_y, q_rd_a}), 0);
    check({tag, "_mv"},     32'({mv_valid, mv_action, mv_x, mv_y}), 0);
    check({tag, "_busy"},   32'(busy), 0);
    check({tag, "_done"},   32'(done), 0);
    check({tag, "_res"},    32'(result), 0);
    check({tag, "_steps"},  32'(steps), 0);
  endtask

  task automatic start_rollout(input string tag);
    obs_q.delete();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check({tag, "_busy_up"}, 32'(busy), 1);
    check({tag, "_done_clr"}, 32'(done), 0);
    check({tag, "_first_rd"}, 32'({q_rd_en, q_rd_x, q_rd_y, q_rd_a}), 32'h100);
    check({tag, "_steps0"}, 32'(steps), 0);
  endtask

  task automatic finish_rollout(input string tag);
    int n;
    int sz;
    n = 0;
    while (!done && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_result"}, 32'(result), 32'(exp_result));
    check({tag, "_steps"}, 32'(steps), 32'(exp_steps));
    check({tag, "_nmoves"}, 32'(obs_q.size()), 32'(exp_q.size()));
    sz = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < sz; i++) check($sformatf("%s_move%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    logic [7:0] held;
    int         n;
    reset_n = 1'b0;
    start   = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    reset_n = 1'b1;

    // All-zero table: straight up, then timeout.
    fill_q(0);
    compute_expected();
    start_rollout("t1");
    finish_rollout("t1");

    // Up the left column then right along the top row to the goal.
    fill_q(0);
    for (int y = 0; y < 4; y++) q_mem[0][y][0] = 16'sd10;
    for (int x = 0; x < 4; x++) q_mem[x][4][3] = 16'sd10;
    compute_expected();
    check("t2_model_len", 32'(exp_q.size()), 8);
    start_rollout("t2");
    finish_rollout("t2");

    // Single move right into a hole.
    fill_q(0);
    q_mem[0][0][3] = 16'sd5;
    compute_expected();
    start_rollout("t3");
    finish_rollout("t3");

    // Negative values with a tie: down wins and is clamped at the edge.
    fill_q(0);
    q_mem[0][0][0] = -16'sd3; q_mem[0][0][1] = -16'sd1;
    q_mem[0][0][2] = -16'sd1; q_mem[0][0][3] = -16'sd5;
    compute_expected();
    start_rollout("t4");
    finish_rollout("t4");
    check("t4_first_move", 32'(obs_q.size() > 0 ? obs_q[0] : 8'hff), 32'({2'd1, 3'd0, 3'd0}));

    // Backpressure: hold the first move for 10 cycles.
    fill_q(0);
    compute_expected();
    force_ready = 1'b0;
    start_rollout("t5");
    n = 0;
    while (!mv_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("t5_valid_seen", 32'(mv_valid), 1);
    held = {mv_action, mv_x, mv_y};
    check("t5_payload", 32'(held), 32'({2'd0, 3'd0, 3'd1}));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("t5_hold_valid", 32'(mv_valid), 1);
      check("t5_hold_payload", 32'({mv_action, mv_x, mv_y}), 32'(held));
      check("t5_hold_no_rd", 32'(q_rd_en), 0);
    end
    check("t5_none_accepted", 32'(obs_q.size()), 0);
    force_ready = 1'b1;
    finish_rollout("t5");

    // Asynchronous reset mid-READ, then a fresh rollout with an ignored start.
    fill_q(0);
    start_rollout("t6a");
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1 check_all_zero("t6_rst");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("t6_no_resume", 32'({busy, q_rd_en, mv_valid}), 0);
    for (int y = 0; y < 4; y++) q_mem[0][y][0] = 16'sd10;
    for (int x = 0; x < 4; x++) q_mem[x][4][3] = 16'sd10;
    compute_expected();
    start_rollout("t6");
    repeat (20) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("t6_busy_kept", 32'(busy), 1);
    finish_rollout("t6");

    // Randomized tables with random backpressure.
    bp_en = 1'b1;
    for (int r = 0; r < 8; r++) begin
      fill_q((r % 2) + 1);
      compute_expected();
      start_rollout($sformatf("rnd%0d", r));
      finish_rollout($sformatf("rnd%0d", r));
    end
    bp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
